// File: rtl/audio_adc_i2s_rx.sv
// rtl/audio_adc_i2s_rx.sv - WM8731 I2S ADC capture into left/right pairs with valid/ready output
// Define AUDIO_RX_FIFO_EN for a FIFO_DEPTH-entry pair FIFO; otherwise a single holding register is used.
module audio_adc_i2s_rx #(
  parameter int SAMPLE_W    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_aud_bclk,
  input  logic                i_aud_adclrck,
  input  logic                i_aud_adcdat,
  output logic [SAMPLE_W-1:0] o_sample_left,
  output logic [SAMPLE_W-1:0] o_sample_right,
  output logic                o_sample_valid,
  input  logic                i_sample_ready,
  output logic                o_overflow,
  input  logic                i_clear_overflow
);

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("audio_adc_i2s_rx: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of 2 >= 2");
  end

  typedef enum logic [1:0] {ST_ALIGN, ST_LEFT, ST_RIGHT} state_t;

  state_t                r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
  logic                  r_bclk_d, r_lrck_d;
  logic                  w_bclk, w_lrck, w_dat;
  logic                  w_bclk_rise, w_lrck_rise, w_lrck_fall;
  logic                  w_latch_left, w_latch_right, w_restart;
  logic                  r_skip;
  logic [SAMPLE_W-1:0]   r_bit_mask, r_shift, r_left, r_right;
  logic                  r_push;
  logic                  w_full, w_pop, w_wr;
  logic                  r_overflow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
      r_bclk_d    <= 1'b0;
      r_lrck_d    <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_aud_bclk};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i_aud_adclrck};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], i_aud_adcdat};
      r_bclk_d    <= w_bclk;
      r_lrck_d    <= w_lrck;
    end
  end

  assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
  assign w_dat       = r_dat_sync[SYNC_STAGES-1];
  assign w_bclk_rise = w_bclk & ~r_bclk_d;
  assign w_lrck_rise = w_lrck & ~r_lrck_d;
  assign w_lrck_fall = ~w_lrck & r_lrck_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_ALIGN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_latch_left  = 1'b0;
    w_latch_right = 1'b0;
    w_restart     = 1'b0;
    case (r_state)
      ST_ALIGN: begin
        if (w_lrck_fall) begin
          w_state_nxt = ST_LEFT;
          w_restart   = 1'b1;
        end
      end
      ST_LEFT: begin
        if (w_lrck_rise) begin
          w_state_nxt  = ST_RIGHT;
          w_latch_left = 1'b1;
          w_restart    = 1'b1;
        end else if (w_lrck_fall) begin
          w_restart = 1'b1;
        end
      end
      ST_RIGHT: begin
        if (w_lrck_fall) begin
          w_state_nxt   = ST_LEFT;
          w_latch_right = 1'b1;
          w_restart     = 1'b1;
        end else if (w_lrck_rise) begin
          w_restart = 1'b1;
        end
      end
      default: w_state_nxt = ST_ALIGN;
    endcase
  end

  // One-hot bit marker walks MSB->LSB; once it empties, extra BCLKs are ignored and short channels keep zero LSBs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_skip     <= 1'b0;
      r_bit_mask <= '0;
      r_shift    <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_push     <= 1'b0;
    end else begin
      r_push <= w_latch_right;
      if (w_latch_left)  r_left  <= r_shift;
      if (w_latch_right) r_right <= r_shift;
      if (w_restart) begin
        r_skip     <= 1'b1;
        r_bit_mask <= {1'b1, {(SAMPLE_W-1){1'b0}}};
        r_shift    <= '0;
      end else if (r_state != ST_ALIGN && w_bclk_rise) begin
        if (r_skip) begin
          r_skip <= 1'b0;
        end else begin
          r_shift    <= r_shift | (r_bit_mask & {SAMPLE_W{w_dat}});
          r_bit_mask <= r_bit_mask >> 1;
        end
      end
    end
  end

  assign w_pop = o_sample_valid & i_sample_ready;
  assign w_wr  = r_push & (~w_full | w_pop);

`ifdef AUDIO_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SAMPLE_W-1:0] r_fifo_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] r_fifo_r [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_count;

  assign w_full         = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_sample_valid = (r_count != '0);
  assign o_sample_left  = r_fifo_l[r_rd_ptr];
  assign o_sample_right = r_fifo_r[r_rd_ptr];

  // When full, a push and pop share the head slot: the old head is read out before the edge overwrites it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_l[i] <= '0;
        r_fifo_r[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_fifo_l[r_wr_ptr] <= r_left;
        r_fifo_r[r_wr_ptr] <= r_right;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [SAMPLE_W-1:0] r_hold_l, r_hold_r;
  logic                r_hold_v;

  assign w_full         = r_hold_v;
  assign o_sample_valid = r_hold_v;
  assign o_sample_left  = r_hold_l;
  assign o_sample_right = r_hold_r;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_hold_v <= 1'b0;
    end else if (w_wr) begin
      r_hold_l <= r_left;
      r_hold_r <= r_right;
      r_hold_v <= 1'b1;
    end else if (w_pop) begin
      r_hold_v <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset)                          r_overflow <= 1'b0;
    else if (r_push & w_full & ~w_pop)    r_overflow <= 1'b1;
    else if (i_clear_overflow)            r_overflow <= 1'b0;
  end

  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// tb/tb_audio_adc_i2s_rx.sv - scoreboard bench for audio_adc_i2s_rx driving an I2S codec model
module tb_audio_adc_i2s_rx;
`ifdef AUDIO_RX_FIFO_EN
  localparam int TB_DEPTH = 4;
`else
  localparam int TB_DEPTH = 1;
`endif
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b1;
  logic        lrck = 1'b1;
  logic        dat = 1'b0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic        rdy_lvl = 1'b0;
  logic [15:0] left, right;
  logic        valid, ovf;

  int          total = 0;
  int          bad = 0;
  int          vcnt = 0;
  int          spurious = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  audio_adc_i2s_rx #(.SAMPLE_W(16), .SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_aud_bclk       (bclk),
    .i_aud_adclrck    (lrck),
    .i_aud_adcdat     (dat),
    .o_sample_left    (left),
    .o_sample_right   (right),
    .o_sample_valid   (valid),
    .i_sample_ready   (ready),
    .o_overflow       (ovf),
    .i_clear_overflow (clr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid) vcnt++;
    if (!reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        mon_e = exp_q.pop_front();
        check("pair_left", {16'h0, left}, {16'h0, mon_e[31:16]});
        check("pair_right", {16'h0, right}, {16'h0, mon_e[15:0]});
      end
    end
  end

  function automatic logic [15:0] align16(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {v, 32'h0} >> n;
    return t[31:16];
  endfunction

  task automatic bit1(input logic lr, input logic d);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    #160;
    bclk = 1'b1;
    #160;
  endtask

  task automatic chan(input logic lr, input logic [31:0] v, input int n);
    bit1(lr, 1'($urandom_range(0, 1)));
    for (int k = n - 1; k >= 0; k--) bit1(lr, v[k]);
  endtask

  // Left + right channel, then a clock-aligned LRCK fall so ready/clear can be hit in the exact push cycle.
  task automatic frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr,
                       input bit keep, input bit prdy, input bit pclr);
    chan(1'b0, l, nl);
    chan(1'b1, r, nr);
    if (keep) exp_q.push_back({align16(l, nl), align16(r, nr)});
    @(posedge clk); #1;
    bclk = 1'b0;
    lrck = 1'b0;
    dat  = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    if (prdy) ready = 1'b1;
    if (pclr) clr = 1'b1;
    @(posedge clk); #1;
    ready = rdy_lvl;
    clr   = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    rdy_lvl = v;
    ready   = v;
  endtask

  task automatic clear_ovf();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_left", {16'h0, left}, 32'h0);
    check("reset_right", {16'h0, right}, 32'h0);
    check("reset_ovf", {31'h0, ovf}, 32'h0);
    reset = 1'b0;

    // basic capture, one valid cycle per frame with ready held high
    set_ready(1'b1);
    vcnt = 0;
    frame(32'h8001, 16, 32'h7FFE, 16, 1, 0, 0);
    repeat (5) @(posedge clk);
    check("t1_valid_pulse", vcnt, 1);
    frame(32'hA5A5, 16, 32'h5A5A, 16, 1, 0, 0);
    frame(32'hFFFF, 16, 32'h0000, 16, 1, 0, 0);
    repeat (5) @(posedge clk);
    check("t1_valid_pulses", vcnt, 3);

    // start mid-right-channel: partial frame must not be emitted
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) bit1(1'b1, 1'($urandom_range(0, 1)));
    frame(32'h1234, 16, 32'hABCD, 16, 1, 0, 0);
    repeat (5) @(posedge clk);
    check("t2_drained", exp_q.size(), 0);

    // stalled consumer: buffer fills in order, later pairs dropped
    set_ready(1'b0);
    for (int i = 0; i < 6; i++) frame(32'h1000 + i, 16, 32'h2000 + i, 16, i < TB_DEPTH, 0, 0);
    #1;
    check("t3_ovf_set", {31'h0, ovf}, 32'h1);
    check("t3_valid_held", {31'h0, valid}, 32'h1);
    set_ready(1'b1);
    repeat (10) @(posedge clk);
    check("t3_drained", exp_q.size(), 0);
    check("t3_ovf_sticky", {31'h0, ovf}, 32'h1);
    clear_ovf();
    check("t3_ovf_cleared", {31'h0, ovf}, 32'h0);
    frame(32'h4321, 16, 32'h8765, 16, 1, 0, 0);
    frame(32'h0F0F, 16, 32'hF0F0, 16, 1, 0, 0);

    // full buffer: pop in the push cycle avoids overflow; set beats clear
    set_ready(1'b0);
    for (int i = 0; i < TB_DEPTH; i++) frame(32'h3000 + i, 16, 32'h3800 + i, 16, 1, 0, 0);
    frame(32'h3100, 16, 32'h3900, 16, 1, 1, 0);
    repeat (3) @(posedge clk); #1;
    check("t4_no_ovf", {31'h0, ovf}, 32'h0);
    frame(32'h3200, 16, 32'h3A00, 16, 0, 0, 1);
    repeat (3) @(posedge clk); #1;
    check("t4_set_beats_clear", {31'h0, ovf}, 32'h1);
    set_ready(1'b1);
    repeat (10) @(posedge clk);
    check("t4_drained", exp_q.size(), 0);
    clear_ovf();
    check("t4_ovf_cleared", {31'h0, ovf}, 32'h0);

    // long and short channels
    frame(32'hABCDEF, 24, 32'h123456, 24, 1, 0, 0);
    frame(32'h000FFF, 12, 32'h0005A5, 12, 1, 0, 0);
    repeat (5) @(posedge clk);
    check("t5_drained", exp_q.size(), 0);

    // reset mid-right-channel with pairs buffered
    set_ready(1'b0);
    frame(32'h5555, 16, 32'h6666, 16, TB_DEPTH >= 1, 0, 0);
    frame(32'h5556, 16, 32'h6667, 16, TB_DEPTH >= 2, 0, 0);
    chan(1'b0, 32'h9999, 16);
    for (int i = 0; i < 7; i++) bit1(1'b1, 1'($urandom_range(0, 1)));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("t6_valid_after_reset", {31'h0, valid}, 32'h0);
    check("t6_ovf_after_reset", {31'h0, ovf}, 32'h0);
    check("t6_left_after_reset", {16'h0, left}, 32'h0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) bit1(1'b1, 1'($urandom_range(0, 1)));
    set_ready(1'b1);
    frame(32'h7777, 16, 32'h8888, 16, 1, 0, 0);
    repeat (20) @(posedge clk);
    check("final_drained", exp_q.size(), 0);
    check("spurious_pairs", spurious, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
